// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// A = Q*B + R. start/busy/done handshake; div_by_zero flags a zero divisor.
// Optional two's-complement operation when SEQ_DIVIDER_SIGNED_EN is defined
// (truncation toward zero, remainder takes the dividend's sign).
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;     // dividend, shifted out MSB-first
  logic [WIDTH-1:0] dvs_q;     // divisor
  logic [WIDTH:0]   rem_q;     // partial remainder, one guard bit
  logic [WIDTH-1:0] quo_q;     // quotient being assembled
  logic [CW-1:0]    cnt_q;     // completed steps
  logic [WIDTH-1:0] q_q, r_q;
  logic             busy_q, done_q, dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_q_q;   // quotient must be negated
  logic             neg_r_q;   // remainder must be negated
`endif

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fin, r_fin;
  logic             accept;

  // One shift-subtract step plus operand/result sign conditioning.
  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    // Extra top bit turns the subtractor borrow into the compare result.
    diff      = {1'b0, rem_shift} - {2'b00, dvs_q};
    borrow    = diff[WIDTH+1];
    rem_d     = borrow ? rem_shift : diff[WIDTH:0];
    quo_d     = {quo_q[WIDTH-2:0], ~borrow};
    accept    = start && (state_q != S_RUN);
`ifdef SEQ_DIVIDER_SIGNED_EN
    a_mag = A[WIDTH-1] ? (~A + ONE) : A;
    b_mag = B[WIDTH-1] ? (~B + ONE) : B;
    q_fin = neg_q_q ? (~quo_d + ONE) : quo_d;
    r_fin = neg_r_q ? (~rem_d[WIDTH-1:0] + ONE) : rem_d[WIDTH-1:0];
`else
    a_mag = A;
    b_mag = B;
    q_fin = quo_d;
    r_fin = rem_d[WIDTH-1:0];
`endif
  end

  // Control FSM and datapath registers; synchronous reset has priority.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
          if (accept) begin
            dvd_q <= a_mag;
            dvs_q <= b_mag;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_q <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_r_q <= A[WIDTH-1];
`endif
            if (B == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              q_q     <= '1;
              r_q     <= A;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            q_q     <= q_fin;
            r_q     <= r_fin;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider; the inverse of the team's combinational array multiplier.
- Takes dividend A and divisor B, each WIDTH bits, and produces quotient Q and remainder R such that A = Q*B + R.
- Computes one quotient bit per clock with one shift-subtract step, reusing a single WIDTH+1-bit subtractor.
- Uses a start/busy/done handshake so it can sit beside the multiplier in the arithmetic datapath.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits (legal range 2 to 32)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  request a division; sampled only in IDLE or DONE
A  input  WIDTH  dividend; sampled on the accepting edge only
B  input  WIDTH  divisor; sampled on the accepting edge only
Q  output  WIDTH  quotient; registered
R  output  WIDTH  remainder; registered
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; Q/R/div_by_zero valid and updated
div_by_zero  output  1  high with done when latched B was 0; holds until next accept

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- rst high at an edge has priority over everything: state=IDLE, step counter=0, internal remainder/quotient/divisor registers=0, Q=0, R=0, busy=0, done=0, div_by_zero=0.
- rst mid-operation aborts the operation; no done is produced for it.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Accept: start=1 at an edge while in IDLE or DONE.
  - Latch A and B, clear the partial remainder (WIDTH+1 bits), clear div_by_zero, counter=0.
  - If B!=0, go to RUN.
  - If B==0, go directly to DONE with Q={WIDTH{1'b1}}, R=A, div_by_zero=1; latency 1 edge.
- start=1 in RUN is ignored: no restart, no error.
- RUN step, once per edge:
  - rem = {rem[WIDTH-1:0], dividend MSB}; shift dividend left by 1.
  - If rem >= {1'b0, divisor}: rem -= divisor and shift 1 into the quotient LSB; else shift in 0.
  - Counter increments.
  - On the edge completing step WIDTH: transfer the final quotient to Q and rem[WIDTH-1:0] to R, go to DONE.
- Latency: start accepted at edge k gives done=1 in the cycle following edge k+WIDTH (WIDTH+1 edges including accept). For WIDTH=4, done is visible after edge k+4.
- DONE → IDLE on the next edge unless start=1, in which case the new operation is accepted (back-to-back; done drops, busy rises).
- Q, R and div_by_zero change only on completion (or accept, for div_by_zero clear) and hold their value in IDLE/RUN until the next completion.
- Boundary cases:
  - A < B gives Q=0, R=A.
  - A=0 gives Q=0, R=0.
  - B=1 gives Q=A, R=0.
  - Maximum operands (all ones / 1) must not overflow the WIDTH+1-bit remainder.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- When defined, A, B, Q and R are two's complement.
- On accept: latch the operand magnitudes and sign bits, then run the same unsigned core.
- On completion:
  - Q is negated if sign(A)^sign(B).
  - R is negated if sign(A), i.e. truncation toward zero; the remainder takes the dividend's sign.
- Most-negative / -1 (e.g. -8/-1 for WIDTH=4) returns Q=most-negative (wrapped), R=0, div_by_zero=0.
- B==0 returns Q={WIDTH{1'b1}}, R=A, div_by_zero=1 as in the unsigned case.
- Latency is unchanged (WIDTH+1 edges).
- When not defined, operands are unsigned and no sign logic is synthesized.

Test Plan:
- WIDTH=4, A=13, B=3, start for one cycle → busy high for 4 cycles, then done pulse with Q=4, R=1, div_by_zero=0; Q/R hold afterwards.
- A=7, B=0 → done in cycle after the accepting edge (no RUN), Q=15, R=7, div_by_zero=1. Next op A=15, B=1 → Q=15, R=0, div_by_zero cleared.
- A=3, B=9 → Q=0, R=3. A=0, B=5 → Q=0, R=0.
- Start A=14, B=4; reassert start with A=1, B=1 during RUN → ignored, result Q=3, R=2. Start held high in DONE → second op accepted back-to-back with no IDLE cycle.
- Start A=15, B=2; assert rst at the 2nd RUN edge → next cycle busy=0, done=0, Q=0, R=0; no done ever appears for the aborted op.
- SEQ_DIVIDER_SIGNED_EN defined, WIDTH=4:
  - A=-7 (4'h9), B=2 → Q=-3 (4'hD), R=-1 (4'hF).
  - A=-8, B=-1 → Q=4'h8, R=0.
  - A=6, B=-4 → Q=-1 (4'hF), R=2.
